// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1-style TAP FSM with capture/shift/update strobes, bypass bit and registered TDO
module tap_controller #(
    parameter int TLR_TMS_COUNT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tms,
    input  logic       tdi,
    input  logic [1:0] instruction,
    input  logic       ir_tdo,
    input  logic       bsr_tdo,
    input  logic       isc_tdo,
    input  logic       bist_tdo,
    output logic [3:0] state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       shift_load,
    output logic       test_norm,
    output logic       ir_reset_n,
    output logic       bist_run,
    output logic       tdo,
    output logic       tdo_en
);
    localparam logic [3:0] TLR      = 4'hF;
    localparam logic [3:0] RTI      = 4'hC;
    localparam logic [3:0] SEL_DR   = 4'h7;
    localparam logic [3:0] CAP_DR   = 4'h6;
    localparam logic [3:0] SH_DR    = 4'h2;
    localparam logic [3:0] EX1_DR   = 4'h1;
    localparam logic [3:0] PAUSE_DR = 4'h3;
    localparam logic [3:0] EX2_DR   = 4'h0;
    localparam logic [3:0] UPD_DR   = 4'h5;
    localparam logic [3:0] SEL_IR   = 4'h4;
    localparam logic [3:0] CAP_IR   = 4'hE;
    localparam logic [3:0] SH_IR    = 4'hA;
    localparam logic [3:0] EX1_IR   = 4'h9;
    localparam logic [3:0] PAUSE_IR = 4'hB;
    localparam logic [3:0] EX2_IR   = 4'h8;
    localparam logic [3:0] UPD_IR   = 4'hD;
    localparam logic [2:0] TLR_CNT  = 3'(TLR_TMS_COUNT);

    logic [3:0] next_state;
    logic [3:0] dr_srcs;
    logic       tdo_src;
    logic       bypass;
    logic [2:0] tms_run;

    // TAP state transition table driven by tms
    always_comb begin
        next_state = TLR;
        case (state)
            TLR:      next_state = tms ? TLR      : RTI;
            RTI:      next_state = tms ? SEL_DR   : RTI;
            SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = tms ? EX1_DR   : SH_DR;
            SH_DR:    next_state = tms ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = tms ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = tms ? SEL_DR   : RTI;
            SEL_IR:   next_state = tms ? TLR      : CAP_IR;
            CAP_IR:   next_state = tms ? EX1_IR   : SH_IR;
            SH_IR:    next_state = tms ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = tms ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = tms ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    assign capture_dr = state == CAP_DR;
    assign shift_dr   = state == SH_DR;
    assign update_dr  = state == UPD_DR;
    assign capture_ir = state == CAP_IR;
    assign shift_ir   = state == SH_IR;
    assign update_ir  = state == UPD_IR;
    assign shift_load = shift_dr;
    assign test_norm  = instruction == 2'b00 && state != TLR;
    assign ir_reset_n = state != TLR;
    assign bist_run   = instruction == 2'b11 && state == RTI;
    assign dr_srcs    = {bist_tdo, isc_tdo, bypass, bsr_tdo};

    // Serial source: IR chain while shifting IR, selected DR while shifting DR, else 0
    always_comb begin
        tdo_src = shift_ir ? ir_tdo : shift_dr ? dr_srcs[instruction] : 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= TLR;
        else     state <= next_state;
    end

    // Registered TDO/enable and the bypass bit (captures 0, shifts tdi under BYPASS)
    always_ff @(posedge clk) begin
        if (rst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
            bypass <= 1'b0;
        end else begin
            tdo    <= tdo_src;
            tdo_en <= shift_ir | shift_dr;
            if (instruction == 2'b01 && (capture_dr || shift_dr)) bypass <= shift_dr & tdi;
        end
    end

    // Run of consecutive tms=1 samples, saturating at the TLR guarantee length
    always_ff @(posedge clk) begin
        if (rst)      tms_run <= 3'd0;
        else if (!tms) tms_run <= 3'd0;
        else if (tms_run != TLR_CNT) tms_run <= tms_run + 3'd1;
    end

    a_tlr_reach: assert property (@(posedge clk) disable iff (rst) tms_run == TLR_CNT |-> state == TLR);
    a_ir_stable: assert property (@(posedge clk) disable iff (rst) shift_dr && $past(shift_dr) |-> $stable(instruction));
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed + randomized checks of tap_controller against a table-driven TAP model
module tb_tap_controller;
    logic       clk = 1'b0;
    logic       rst, tms, tdi;
    logic [1:0] instruction;
    logic       ir_tdo, bsr_tdo, isc_tdo, bist_tdo;
    logic [3:0] state;
    logic       capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
    logic       shift_load, test_norm, ir_reset_n, bist_run, tdo, tdo_en;

    int checks = 0;
    int failures = 0;

    localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6, SHDR = 4'h2;
    localparam logic [3:0] EX1DR = 4'h1, PAUSEDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5;
    localparam logic [3:0] SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA, EX1IR = 4'h9;
    localparam logic [3:0] PAUSEIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;

    logic [3:0] nx0 [16];
    logic [3:0] nx1 [16];
    logic [3:0] m_state;
    logic       m_tdo, m_en, m_byp;

    tap_controller dut (
        .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .instruction(instruction),
        .ir_tdo(ir_tdo), .bsr_tdo(bsr_tdo), .isc_tdo(isc_tdo), .bist_tdo(bist_tdo),
        .state(state), .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .shift_load(shift_load), .test_norm(test_norm), .ir_reset_n(ir_reset_n),
        .bist_run(bist_run), .tdo(tdo), .tdo_en(tdo_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tr(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
        nx0[s] = on0;
        nx1[s] = on1;
    endtask

    // Behavioural model of one clock edge using the inputs present at that edge
    task automatic model_edge();
        logic [3:0] srcs;
        if (rst) begin
            m_state = TLR;
            m_tdo = 1'b0;
            m_en = 1'b0;
            m_byp = 1'b0;
        end else begin
            srcs = {bist_tdo, isc_tdo, m_byp, bsr_tdo};
            m_tdo = (m_state == SHIR) ? ir_tdo : (m_state == SHDR) ? srcs[instruction] : 1'b0;
            m_en = (m_state == SHIR) || (m_state == SHDR);
            if (instruction == 2'b01 && m_state == CAPDR) m_byp = 1'b0;
            if (instruction == 2'b01 && m_state == SHDR) m_byp = tdi;
            m_state = tms ? nx1[m_state] : nx0[m_state];
        end
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("capture_dr", capture_dr, m_state == CAPDR);
        chk("shift_dr", shift_dr, m_state == SHDR);
        chk("update_dr", update_dr, m_state == UPDDR);
        chk("capture_ir", capture_ir, m_state == CAPIR);
        chk("shift_ir", shift_ir, m_state == SHIR);
        chk("update_ir", update_ir, m_state == UPDIR);
        chk("shift_load", shift_load, m_state == SHDR);
        chk("test_norm", test_norm, instruction == 2'b00 && m_state != TLR);
        chk("ir_reset_n", ir_reset_n, m_state != TLR);
        chk("bist_run", bist_run, instruction == 2'b11 && m_state == RTI);
        chk("tdo", tdo, m_tdo);
        chk("tdo_en", tdo_en, m_en);
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        ir_tdo = 1'($urandom);
        bsr_tdo = 1'($urandom);
        isc_tdo = 1'($urandom);
        bist_tdo = 1'($urandom);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] seq_rti [5] = '{SELDR, SELIR, TLR, TLR, TLR};
        logic [3:0] seq_sh  [5] = '{EX1DR, UPDDR, SELDR, SELIR, TLR};
        logic [3:0] seq_ir  [9] = '{RTI, SELDR, SELIR, CAPIR, SHIR, SHIR, EX1IR, UPDIR, RTI};
        logic       tms_ir  [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        logic       tdo_exp [3] = '{0, 1, 0};
        logic       tdi_seq [3] = '{1, 0, 1};
        int n_cap, n_sh, n_upd, n_bist;
        tr(TLR, RTI, TLR);       tr(RTI, RTI, SELDR);
        tr(SELDR, CAPDR, SELIR); tr(SELIR, CAPIR, TLR);
        tr(CAPDR, SHDR, EX1DR);  tr(SHDR, SHDR, EX1DR);
        tr(EX1DR, PAUSEDR, UPDDR); tr(PAUSEDR, PAUSEDR, EX2DR);
        tr(EX2DR, SHDR, UPDDR);  tr(UPDDR, RTI, SELDR);
        tr(CAPIR, SHIR, EX1IR);  tr(SHIR, SHIR, EX1IR);
        tr(EX1IR, PAUSEIR, UPDIR); tr(PAUSEIR, PAUSEIR, EX2IR);
        tr(EX2IR, SHIR, UPDIR);  tr(UPDIR, RTI, SELDR);
        m_state = TLR; m_tdo = 0; m_en = 0; m_byp = 0;
        instruction = 2'b00;
        tdi = 0; tms = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom));
        chk("rst_state", state, TLR);
        chk("rst_tdo", tdo, 0);
        chk("rst_tdo_en", tdo_en, 0);
        chk("rst_ir_reset_n", ir_reset_n, 0);
        chk("rst_test_norm", test_norm, 0);
        rst = 1'b0;
        step(0, 0);
        chk("to_rti", state, RTI);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            chk("rti_ones", state, seq_rti[i]);
        end
        n_cap = 0; n_sh = 0; n_upd = 0;
        for (int i = 0; i < 9; i++) begin
            step(tms_ir[i], 0);
            chk("ir_scan_seq", state, seq_ir[i]);
            n_cap += int'(capture_ir);
            n_sh += int'(shift_ir);
            n_upd += int'(update_ir);
        end
        chk("capture_ir_count", 4'(n_cap), 4'd1);
        chk("shift_ir_count", 4'(n_sh), 4'd2);
        chk("update_ir_count", 4'(n_upd), 4'd1);
        instruction = 2'b01;
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("byp_in_shdr", state, SHDR);
        n_upd = 0;
        for (int i = 0; i < 3; i++) begin
            step(i == 2, tdi_seq[i]);
            chk("bypass_tdo", tdo, tdo_exp[i]);
            chk("bypass_tdo_en", tdo_en, 1);
        end
        step(1, 0);
        n_upd += int'(update_dr);
        chk("byp_upd_state", state, UPDDR);
        step(0, 0);
        n_upd += int'(update_dr);
        chk("update_dr_count", 4'(n_upd), 4'd1);
        instruction = 2'b00;
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("bsr_shift_load", shift_load, 1);
        chk("bsr_test_norm", test_norm, 1);
        step(0, 0);
        chk("bsr_tdo_follow", tdo, bsr_tdo);
        step(1, 0);
        step(0, 0);
        chk("pause_state", state, PAUSEDR);
        chk("pause_shift_dr", shift_dr, 0);
        chk("pause_tdo_en", tdo_en, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        chk("back_rti", state, RTI);
        instruction = 2'b11;
        #1;
        n_bist = int'(bist_run);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_bist += int'(bist_run);
        end
        step(1, 0);
        n_bist += int'(bist_run);
        chk("bist_run_count", 4'(n_bist), 4'd4);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        chk("mid_scan_shdr", state, SHDR);
        rst = 1'b1;
        step(0, 0);
        chk("abort_state", state, TLR);
        chk("abort_no_update", update_dr, 0);
        rst = 1'b0;
        step(0, 0);
        chk("abort_no_update2", update_dr, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("sh_again", state, SHDR);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            chk("shdr_ones", state, seq_sh[i]);
        end
        for (int i = 0; i < 600; i++) begin
            if (m_state == RTI && $urandom_range(0, 7) == 0) instruction = 2'($urandom);
            rst = ($urandom_range(0, 40) == 0);
            step(1'($urandom), 1'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
